scalable_seq_generator: RTL

- Serial pattern transmitter for scalable_seq_detector: emits the 2^STATE_BITS-bit pattern on `x`, one bit per accepted cycle, LSB (bit 0) first.
- Sends one frame or a burst of back-to-back frames, so a detector with the same STATE_BITS driven by `x` reaches its stop state once per frame.
- Used as a stimulus/loopback partner for the detector on the same clock domain.

---
 rtl/scalable_seq_generator.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/scalable_seq_generator.sv
// -----------------------------------------------------------------------------
// scalable_seq_generator
// Serial pattern transmitter. On an accepted start it captures an N-bit pattern
// (N = 2**STATE_BITS) and a repeat count, then shifts the pattern out on x,
// LSB first, one bit per accepted cycle, for repeat_count+1 back-to-back
// frames. Intended as a stimulus/loopback partner for scalable_seq_detector.
//
// Ports:
//   clock0        in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   start         in   burst request, sampled only while idle
//   abort         in   synchronous burst cancel (wins over start and done)
//   ready_in      in   downstream accept; 0 holds the current bit
//   sequence_str  in   pattern, captured on accepted start
//   repeat_count  in   frames-1, captured on accepted start
//   x             out  serial pattern bit
//   x_valid       out  x carries a pattern bit
//   busy          out  burst in progress
//   done          out  one-cycle pulse at normal burst completion
//   bit_index     out  index of the bit currently on x
//   frames_sent   out  frames completed in the current or last burst
// -----------------------------------------------------------------------------
module scalable_seq_generator #(
    parameter int STATE_BITS  = 3,
    parameter int REPEAT_BITS = 4
) (
    input  logic                          clock0,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          ready_in,
    input  logic [(2**STATE_BITS)-1:0]    sequence_str,
    input  logic [REPEAT_BITS-1:0]        repeat_count,
    output logic                          x,
    output logic                          x_valid,
    output logic                          busy,
    output logic                          done,
    output logic [STATE_BITS-1:0]         bit_index,
    output logic [REPEAT_BITS:0]          frames_sent
);

    localparam int N = 2 ** STATE_BITS;
    localparam logic [STATE_BITS-1:0] LAST_IDX = STATE_BITS'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q,  state_d;
    logic [N-1:0]            shadow_q, shadow_d;
    logic [REPEAT_BITS-1:0]  rep_q,    rep_d;
    logic [STATE_BITS-1:0]   idx_q,    idx_d;
    logic [REPEAT_BITS:0]    frames_q, frames_d;
    logic                    done_q,   done_d;
    logic                    x_q,      x_d;
    logic                    busy_q,   busy_d;

    // Next-state, counter and output computation.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        rep_d    = rep_q;
        idx_d    = idx_q;
        frames_d = frames_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // abort has priority over start while idle
                if (start && !abort) begin
                    shadow_d = sequence_str;
                    rep_d    = repeat_count;
                    frames_d = '0;
                    idx_d    = '0;
                    state_d  = SEND;
                end else begin
                    state_d  = IDLE;
                end
            end
            SEND: begin
                if (abort) begin
                    // no done pulse and the frame in flight is not counted
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (ready_in) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + STATE_BITS'(1);
                    end else begin
                        frames_d = frames_q + (REPEAT_BITS + 1)'(1);
                        idx_d    = '0;
                        // frames_q counts frames finished before this one,
                        // so equality with the captured count means last frame
                        if (frames_q == {1'b0, rep_q}) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = SEND;
                        end
                    end
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        // Outputs are registered: present the bit that will be on the line
        // after this edge.
        if (state_d == SEND) begin
            busy_d = 1'b1;
            x_d    = shadow_d[idx_d];
        end else begin
            busy_d = 1'b0;
            x_d    = 1'b0;
        end
    end

    // State, shadow and output registers.
    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            rep_q    <= '0;
            idx_q    <= '0;
            frames_q <= '0;
            done_q   <= 1'b0;
            x_q      <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            rep_q    <= rep_d;
            idx_q    <= idx_d;
            frames_q <= frames_d;
            done_q   <= done_d;
            x_q      <= x_d;
            busy_q   <= busy_d;
        end
    end

    assign x           = x_q;
    assign x_valid     = busy_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign bit_index   = idx_q;
    assign frames_sent = frames_q;

endmodule
